// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the shared 16-bit memory port for fetch (0) and data (1).
// Optional MEMARB_PERF_EN adds saturating per-requester grant counters GCNT0/GCNT1.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ0,
    input  logic [15:0] ADDR0,
    input  logic        REQ1,
    input  logic [15:0] ADDR1,
    input  logic [15:0] WDATA1,
    input  logic        WE1,
    input  logic [15:0] MEM_RDATA,
    output logic        SEL,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic [15:0] RDATA,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic        BUSY
`ifdef MEMARB_PERF_EN
    ,
    output logic [15:0] GCNT0,
    output logic [15:0] GCNT1
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d, we_q, we_d, last_q, last_d;
    logic               en_q, en_d, mem_we_q, mem_we_d, busy_q, busy_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
    logic [15:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win;
`ifdef MEMARB_PERF_EN
    logic [15:0]        gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        en_d    = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        // Under contention the requester that did not go last wins.
        win     = (REQ0 && REQ1) ? ~last_q : REQ1;
`ifdef MEMARB_PERF_EN
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
`endif
        case (state_q)
            IDLE: if (REQ0 || REQ1) begin
                state_d = ACCESS;
                sel_d   = win;
                addr_d  = win ? ADDR1 : ADDR0;
                wdata_d = win ? WDATA1 : 16'h0000;
                we_d    = win & WE1;
                cnt_d   = CNT_W'(MEM_LAT - 1);
                en_d    = 1'b1;
                gnt0_d  = ~win;
                gnt1_d  = win;
`ifdef MEMARB_PERF_EN
                gcnt0_d = (!win && gcnt0_q != 16'hFFFF) ? gcnt0_q + 16'd1 : gcnt0_q;
                gcnt1_d = (win && gcnt1_q != 16'hFFFF) ? gcnt1_q + 16'd1 : gcnt1_q;
`endif
            end
            ACCESS: if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
                en_d  = 1'b1;
            end else begin
                rdata_d = we_q ? rdata_q : MEM_RDATA;
                state_d = RESP;
                done0_d = ~sel_q;
                done1_d = sel_q;
            end
            RESP: begin
                last_d  = sel_q;
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        mem_we_d = en_d & we_d;
        busy_d   = state_d != IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            mem_we_q <= mem_we_d;
            busy_q   <= busy_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
        end
    end

`ifdef MEMARB_PERF_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign GCNT0 = gcnt0_q;
    assign GCNT1 = gcnt1_q;
`endif

    assign SEL       = sel_q;
    assign MEM_EN    = en_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign RDATA     = rdata_q;
    assign GNT0      = gnt0_q;
    assign GNT1      = gnt1_q;
    assign DONE0     = done0_q;
    assign DONE1     = done1_q;
    assign BUSY      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, reset/alternation sequences and a randomized
// run against a transaction-phase reference model of the memory port arbiter.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    localparam int P   = LAT + 2;

    logic        CLK, RST_N, REQ0, REQ1, WE1, SEL, MEM_EN, MEM_WE;
    logic        GNT0, GNT1, DONE0, DONE1, BUSY;
    logic [15:0] ADDR0, ADDR1, WDATA1, MEM_RDATA, MEM_ADDR, MEM_WDATA, RDATA;
`ifdef MEMARB_PERF_EN
    logic [15:0] GCNT0, GCNT1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.MEM_LAT(LAT), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .ADDR0(ADDR0), .REQ1(REQ1),
        .ADDR1(ADDR1), .WDATA1(WDATA1), .WE1(WE1), .MEM_RDATA(MEM_RDATA),
        .SEL(SEL), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .RDATA(RDATA), .GNT0(GNT0), .GNT1(GNT1),
        .DONE0(DONE0), .DONE1(DONE1), .BUSY(BUSY)
`ifdef MEMARB_PERF_EN
        , .GCNT0(GCNT0), .GCNT1(GCNT1)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        r0;
        logic [15:0] a0;
        logic        r1;
        logic [15:0] a1;
        logic [15:0] wd1;
        logic        we1;
        logic [15:0] mrd;
        logic        esel;
        logic [15:0] eaddr;
        logic [15:0] ewd;
        logic        ewe;
        logic [15:0] erd;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        {REQ0, REQ1, WE1} = '0;
        {ADDR0, ADDR1, WDATA1, MEM_RDATA} = '0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    int          ph;
    logic        m_last, m_sel, m_we, en;
    logic [15:0] m_addr, m_wd, m_rd;

    initial begin
        RST_N = 1'b0;
        tbl[0] = '{1, 16'h0040, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 0, 16'h0040, 16'h0000, 0, 16'hBEEF};
        tbl[1] = '{0, 16'h0000, 1, 16'h1000, 16'h1234, 1, 16'h5555, 1, 16'h1000, 16'h1234, 1, 16'hBEEF};
        tbl[2] = '{1, 16'h0100, 1, 16'h2000, 16'hAAAA, 0, 16'h0A0A, 0, 16'h0100, 16'h0000, 0, 16'h0A0A};
        tbl[3] = '{1, 16'h0200, 1, 16'h3000, 16'h7777, 1, 16'h9999, 1, 16'h3000, 16'h7777, 1, 16'h0A0A};
        tbl[4] = '{1, 16'h0300, 1, 16'h4000, 16'h0000, 0, 16'hC0DE, 0, 16'h0300, 16'h0000, 0, 16'hC0DE};

        do_reset();
        check("reset_outputs", {SEL, MEM_EN, MEM_WE, GNT0, GNT1, DONE0, DONE1, BUSY, MEM_ADDR, MEM_WDATA, RDATA}, '0);

        for (int i = 0; i < 5; i++) begin
            REQ0 = tbl[i].r0; ADDR0 = tbl[i].a0; REQ1 = tbl[i].r1; ADDR1 = tbl[i].a1;
            WDATA1 = tbl[i].wd1; WE1 = tbl[i].we1; MEM_RDATA = tbl[i].mrd;
            for (int c = 0; c < LAT; c++) begin
                @(negedge CLK);
                check($sformatf("vec%0d_access%0d", i, c),
                      {GNT0, GNT1, SEL, MEM_EN, MEM_WE, BUSY, MEM_ADDR, MEM_WDATA},
                      {~tbl[i].esel, tbl[i].esel, tbl[i].esel, 1'b1, tbl[i].ewe, 1'b1, tbl[i].eaddr, tbl[i].ewd});
                // Latched values must survive request and operand churn.
                REQ0 = 1'b0; REQ1 = 1'b0;
                ADDR0 = ~tbl[i].a0; ADDR1 = ~tbl[i].a1; WDATA1 = ~tbl[i].wd1; WE1 = ~tbl[i].we1;
            end
            @(negedge CLK);
            check($sformatf("vec%0d_resp", i), {DONE0, DONE1, MEM_EN, MEM_WE, GNT0, GNT1, BUSY, RDATA},
                  {~tbl[i].esel, tbl[i].esel, 1'b0, 1'b0, ~tbl[i].esel, tbl[i].esel, 1'b1, tbl[i].erd});
            @(negedge CLK);
            check($sformatf("vec%0d_idle", i), {DONE0, DONE1, GNT0, GNT1, BUSY, MEM_EN}, '0);
        end
`ifdef MEMARB_PERF_EN
        check("gcnt", {GCNT0, GCNT1}, {16'd3, 16'd2});
`endif

        do_reset();
        REQ0 = 1'b1; ADDR0 = 16'h0040;
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("rst_mid_access", {MEM_EN, MEM_WE, GNT0, GNT1, DONE0, DONE1, BUSY}, '0);
        REQ1 = 1'b1; ADDR1 = 16'h5000;
        @(negedge CLK);
        check("rst_held_no_done", {MEM_EN, GNT0, GNT1, DONE0, DONE1, BUSY}, '0);
        RST_N = 1'b1;
        for (int c = 0; c < 4 * P; c++) begin
            @(negedge CLK);
            check($sformatf("alt_c%0d", c), {GNT0, GNT1, DONE0, DONE1},
                  {((c / P) % 2 == 0) && (c % P <= LAT), ((c / P) % 2 == 1) && (c % P <= LAT),
                   ((c / P) % 2 == 0) && (c % P == LAT), ((c / P) % 2 == 1) && (c % P == LAT)});
        end
        REQ0 = 1'b0; REQ1 = 1'b0;

        do_reset();
        ph = 0; m_last = 1'b1; m_sel = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_rd = '0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge CLK);
            en = (ph >= 1) && (ph <= LAT);
            check("rand", {SEL, MEM_EN, MEM_WE, GNT0, GNT1, DONE0, DONE1, BUSY, MEM_ADDR, MEM_WDATA, RDATA},
                  {m_sel, en, en & m_we, (ph >= 1) && !m_sel, (ph >= 1) && m_sel,
                   (ph == LAT + 1) && !m_sel, (ph == LAT + 1) && m_sel, ph != 0, m_addr, m_wd, m_rd});
            REQ0 = $urandom_range(0, 3) != 0;
            REQ1 = $urandom_range(0, 2) != 0;
            ADDR0 = 16'($urandom); ADDR1 = 16'($urandom); WDATA1 = 16'($urandom);
            WE1 = 1'($urandom); MEM_RDATA = 16'($urandom);
            // Phase 0 = idle, 1..LAT = memory cycles, LAT+1 = completion cycle.
            if (ph == 0) begin
                if (REQ0 || REQ1) begin
                    m_sel  = (REQ0 && REQ1) ? !m_last : REQ1;
                    m_addr = m_sel ? ADDR1 : ADDR0;
                    m_wd   = m_sel ? WDATA1 : 16'h0000;
                    m_we   = m_sel && WE1;
                    ph     = 1;
                end
            end else if (ph <= LAT) begin
                if (ph == LAT && !m_we) m_rd = MEM_RDATA;
                ph++;
            end else begin
                m_last = m_sel;
                ph     = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
